// File: rtl/c1_pkg.sv
// Shared definitions for the streaming one's-complement checksum block.
package c1_pkg;

  localparam int W_DEF  = 4;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } c1_state_t;

endpackage

// File: rtl/c1_add_w.sv
// W-bit one's-complement adder, end-around carry, no carry-in.
module c1_add_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] s;

  // Folding the carry back in can never carry out again.
  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    y = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
  end

endmodule

// File: rtl/c1_checksum4b.sv
// Streaming one's-complement checksum accumulator.
module c1_checksum4b
  import c1_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_ok,
  output logic [CW-1:0] out_len
);

  c1_state_t state, state_next;

  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic          release_out;

  c1_add_w #(.W(W)) u_add (
    .a (acc),
    .b (in_data),
    .y (acc_next)
  );

  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign cnt_next    = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_next = in_last ? DONE : ACC;
        ACC:  if (accept && in_last) state_next = DONE;
        DONE: if (release_out) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != DONE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_ok  <= 1'b0;
      out_len <= '0;
    end else if (clr || release_out) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (in_last) begin
        out_sum <= ~acc_next;
        out_ok  <= (acc_next == {W{1'b1}});
        out_len <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_c1_checksum4b.sv
// Directed self-checking bench for c1_checksum4b.
module tb_c1_checksum4b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_sum;
  logic       out_ok;
  logic [7:0] out_len;

  int checks = 0;
  int failures = 0;

  c1_checksum4b dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ok    (out_ok),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 4'h0 ||
        out_ok !== 1'b0 || out_len !== 8'd0) begin
      failures++;
      $display("FAIL reset: v=%b r=%b sum=%h ok=%b len=%0d exp v=0 r=1 sum=0 ok=0 len=0",
               out_valid, in_ready, out_sum, out_ok, out_len);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    beat(4'h5, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'hA || out_ok !== 1'b0 || out_len !== 8'd1) begin
      failures++;
      $display("FAIL single: v=%b sum=%h ok=%b len=%0d exp v=1 sum=a ok=0 len=1",
               out_valid, out_sum, out_ok, out_len);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_release: v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_fold();
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL last_no_valid: v=%b exp 0", out_valid);
    end
    beat(4'h9, 1'b0);
    beat(4'h8, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'hD || out_ok !== 1'b0 || out_len !== 8'd2) begin
      failures++;
      $display("FAIL fold: v=%b sum=%h ok=%b len=%0d exp v=1 sum=d ok=0 len=2",
               out_valid, out_sum, out_ok, out_len);
    end
    drain();
  endtask

  task automatic test_verify();
    beat(4'h3, 1'b0);
    beat(4'h6, 1'b0);
    beat(4'h6, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'h0 || out_ok !== 1'b1 || out_len !== 8'd3) begin
      failures++;
      $display("FAIL verify: v=%b sum=%h ok=%b len=%0d exp v=1 sum=0 ok=1 len=3",
               out_valid, out_sum, out_ok, out_len);
    end
    drain();
  endtask

  task automatic test_backpressure();
    beat(4'hF, 1'b0);
    beat(4'h1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'hE || out_ok !== 1'b0 || out_len !== 8'd2) begin
      failures++;
      $display("FAIL carry: v=%b sum=%h ok=%b len=%0d exp v=1 sum=e ok=0 len=2",
               out_valid, out_sum, out_ok, out_len);
    end
    in_valid = 1'b1;
    in_data  = 4'h4;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 4'hE || out_len !== 8'd2) begin
        failures++;
        $display("FAIL hold[%0d]: v=%b r=%b sum=%h len=%0d exp v=1 r=0 sum=e len=2",
                 i, out_valid, in_ready, out_sum, out_len);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    beat(4'h4, 1'b1);
    checks++;
    if (out_sum !== 4'hB || out_len !== 8'd1) begin
      failures++;
      $display("FAIL not_absorbed: sum=%h len=%0d exp sum=b len=1", out_sum, out_len);
    end
    drain();
  endtask

  task automatic test_async_reset();
    beat(4'h7, 1'b0);
    beat(4'h2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 4'h0 || out_len !== 8'd0) begin
      failures++;
      $display("FAIL async_rst: v=%b r=%b sum=%h len=%0d exp v=0 r=1 sum=0 len=0",
               out_valid, in_ready, out_sum, out_len);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    beat(4'h7, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'h8 || out_len !== 8'd1) begin
      failures++;
      $display("FAIL post_rst: v=%b sum=%h len=%0d exp v=1 sum=8 len=1",
               out_valid, out_sum, out_len);
    end
    drain();
  endtask

  task automatic test_clr_zero();
    beat(4'hC, 1'b0);
    clr = 1'b1;
    beat(4'h3, 1'b0);
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr: v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    beat(4'h0, 1'b0);
    beat(4'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'hF || out_ok !== 1'b0 || out_len !== 8'd2) begin
      failures++;
      $display("FAIL zero_pkt: v=%b sum=%h ok=%b len=%0d exp v=1 sum=f ok=0 len=2",
               out_valid, out_sum, out_ok, out_len);
    end
    out_ready = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 4'hF) begin
      failures++;
      $display("FAIL clr_done: v=%b sum=%h exp v=0 sum=f", out_valid, out_sum);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 259; i++) beat(4'h1, 1'b0);
    beat(4'h1, 1'b1);
    // 260 ones: 260 mod 15 = 5, so acc=5 and checksum a.
    checks++;
    if (out_valid !== 1'b1 || out_len !== 8'd255 || out_sum !== 4'hA) begin
      failures++;
      $display("FAIL saturate: v=%b len=%0d sum=%h exp v=1 len=255 sum=a",
               out_valid, out_len, out_sum);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fold();
    test_verify();
    test_backpressure();
    test_async_reset();
    test_clr_zero();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c1_checksum4b.md
Name: c1_checksum4b

Overview:
Streaming one's-complement checksum accumulator that sits directly downstream of the 4-bit one's-complement adder stage.
- Accepts a packet of W-bit words over a valid/ready handshake.
- Folds each word into a running one's-complement sum using end-around carry.
- At end of packet, presents the checksum (bitwise NOT of the sum), a verify flag and the word count over a valid/ready output handshake.

Parameters:
W, 4, data/accumulator width in bits
CW, 8, width of the word counter out_len

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous abort; drops the packet in progress
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word
in_data  input  W  data word
in_last  input  1  marks final word of the packet
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  W  checksum = ~acc
out_ok  output  1  1 when acc == all ones (packet including its checksum verifies)
out_len  output  CW  words accepted in the packet, saturating

Behaviour:
- Reset, async on rst=1: state=IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_ok=0, out_len=0. All outputs change immediately, not at the next edge.
- States: IDLE (no word yet), ACC (at least one word accepted), DONE (result held).
- in_ready = (state != DONE), decoded from state only, with no combinational path from in_valid or out_ready.
- Accept = in_valid && in_ready, sampled at the rising edge.
- On accept, acc <= c1add(acc, in_data) and cnt <= cnt+1.
  - cnt saturates at 2^CW-1.
- c1add(a,b), no carry-in:
  - s = a + b, computed W+1 bits wide.
  - result = s[W-1:0] + s[W], truncated to W bits.
  - Max s = 2^(W+1)-2, so this never overflows twice.
- Transitions:
  - IDLE: accept with in_last=0 -> ACC; accept with in_last=1 -> DONE.
  - ACC: accept with in_last=1 -> DONE; otherwise stay in ACC.
  - DONE: out_valid && out_ready -> IDLE, with acc=0 and cnt=0.
- Entering DONE registers the outputs from the updated values:
  - out_sum = ~acc_next
  - out_ok = (acc_next == all ones)
  - out_len = cnt_next
- Latency: out_valid rises on the edge that accepts the last word and is visible one cycle after that beat is presented.
- In DONE:
  - out_valid=1; out_sum, out_ok and out_len are stable until the handshake completes.
  - in_ready=0, and in_valid is ignored.
- After the output handshake, in_ready=1 again in the following cycle. No same-cycle restart.
- Both zeros: acc starts at 0000, and an all-zero packet gives acc=0000, out_sum=all ones, out_ok=0. Negative zero (all ones) arises only through data.
- clr=1 at an edge:
  - state=IDLE, acc=0, cnt=0, out_valid=0.
  - Takes precedence over accept and over the output handshake in the same cycle.
- in_last with in_valid=0 is ignored.
- Outside DONE, out_sum, out_ok and out_len hold their last values (0 after reset).

Decomposition:
- Shared package c1_pkg:
  - state encoding constants: IDLE=2'd0, ACC=2'd1, DONE=2'd2
  - default widths W=4, CW=8
- One sub-module: c1_add_w.
  - Parameterised W-bit one's-complement adder with end-around carry and no carry-in.
  - Instantiated once on the acc/in_data path.

Test Plan:
1. Reset, then a single beat in_data=0x5, in_last=1, out_ready=1 -> out_valid=1 next cycle; out_sum=0xA, out_ok=0, out_len=1.
2. Beats 0x9, then 0x8 with last -> 9+8=0x11, folds to 0x2; out_sum=0xD, out_len=2.
3. Verify path: beats 0x3, 0x6, then 0x6 with last (0x6 is the checksum of 3,6) -> acc=0xF; out_ok=1, out_sum=0x0, out_len=3.
4. Backpressure and end-around carry: 0xF then 0x1 with last, out_ready held 0 for 5 cycles.
   - Result: acc=0x1, out_sum=0xE.
   - While held: out_valid stays 1, outputs stable, in_ready=0, and a concurrent in_valid beat of 0x4 is not absorbed.
   - After out_ready=1: out_valid=0 and in_ready=1 on the next cycle.
5. Async reset mid-packet: after accepting 0x7, 0x2, assert rst between edges -> out_valid=0 and in_ready=1 immediately. Then a fresh beat 0x7 with last gives out_sum=0x8, out_len=1.
6. clr mid-packet, and all-zero packet: after 0xC, assert clr=1 together with in_valid=1, in_data=0x3 -> that beat is dropped and state returns to IDLE. Then 0x0, 0x0 with last -> out_sum=0xF, out_ok=0, out_len=2.
